fragment_cull_queue: RTL and testbench
======================================

Name: fragment_cull_queue

Overview:
- Sits directly downstream of the pixel generator, consuming its x/y/barycentric-weight/area stream with the same valid/busy handshake.
- Discards fragments outside the triangle (any negative edge weight), with zero area, or outside the framebuffer.
- Computes the linear framebuffer address for each survivor and buffers it in a FIFO, decoupling the generator from the framebuffer writer.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels; x >= FB_WIDTH is culled.
- FB_HEIGHT, 480, framebuffer height in pixels; y >= FB_HEIGHT is culled.
- ADDR_W, 20, width of the linear address output.
- FIFO_DEPTH, 8, survivor FIFO entries; power of two, >= 4.

Ports:
- fragment_clock_i  in  1  clock
- fragment_reset_i  in  1  asynchronous, active-low reset
- x_i  in  12  fragment x
- y_i  in  12  fragment y
- w0_i  in  25  edge weight 0, two's complement
- w1_i  in  25  edge weight 1, two's complement
- w2_i  in  25  edge weight 2, two's complement
- area_i  in  24  triangle area, unsigned
- valid_i  in  1  input fragment valid
- busy_o  out  1  stage cannot accept; upstream holds
- frag_x_o  out  12  surviving fragment x
- frag_y_o  out  12  surviving fragment y
- frag_addr_o  out  ADDR_W  y*FB_WIDTH + x
- frag_w0_o  out  25  weight 0, passed through
- frag_w1_o  out  25  weight 1, passed through
- frag_w2_o  out  25  weight 2, passed through
- frag_area_o  out  24  area, passed through
- frag_valid_o  out  1  FIFO head valid
- frag_busy_i  in  1  downstream stall

Behaviour:
- Reset (fragment_reset_i low, asynchronous): all pipeline valids clear, FIFO pointers and count go to 0, all outputs 0, busy_o=0.
- Input transfer occurs on a rising edge with valid_i=1 and busy_o=0. Input is ignored while busy_o=1; upstream must hold its data.
- Stage S1 registers the input together with a keep flag.
  - keep = !w0[24] & !w1[24] & !w2[24] & (area!=0) & (x<FB_WIDTH) & (y<FB_HEIGHT).
  - Weight 0 counts as inside.
- Stage S2 registers S1, computes addr = y*FB_WIDTH + x truncated to ADDR_W, and carries keep.
- FIFO write occurs when S2 is valid and keep=1. Culled fragments drop at S2 and never occupy the FIFO.
- S1 and S2 advance every cycle; there is no internal stall. Overflow is prevented by flow control:
  - busy_o = (fifo_count + s1_valid + s2_valid) >= FIFO_DEPTH, combinational from registers.
- Output side:
  - frag_valid_o = (fifo_count != 0).
  - Output data is the FIFO head.
  - Pop occurs when frag_valid_o=1 and frag_busy_i=0.
- Simultaneous push and pop leaves the count unchanged. Push to an empty FIFO is visible one cycle later; there is no bypass.
- Pointers wrap modulo FIFO_DEPTH. Full is count==FIFO_DEPTH and empty is count==0. Both are unreachable-overflow / underflow-safe by construction.
- Latency: a fragment accepted at edge N is in S1 after N and S2 after N+1, is written at N+2, and frag_valid_o=1 after edge N+2. That is 3 cycles with an empty FIFO.
- Throughput is 1 fragment/cycle when frag_busy_i=0.
- Order is preserved.
- Output fields are stable while frag_valid_o=1 and frag_busy_i=1.

Optional Feature:
- FRAG_CULL_STATS_EN
- Defined: adds outputs stat_accepted_o[31:0] and stat_culled_o[31:0].
  - Each increments once per fragment leaving S2 (kept or culled respectively).
  - Both wrap at 2^32 and reset to 0.
  - Adds input stat_clear_i, which zeroes both counters synchronously. If an increment occurs in the same cycle as stat_clear_i, the counter still ends at 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: fill the FIFO with 3 entries, pull fragment_reset_i low asynchronously -> all outputs 0 immediately; after release, frag_valid_o stays 0 until a new input arrives.
- Single inside fragment x=10, y=2, w=(5,0,7), area=12 accepted at edge N, frag_busy_i=0 -> frag_valid_o=1 after edge N+2; frag_addr_o=1290; weights and area echoed.
- Cull set: x=700; y=480; w1=-1 (0x1FFFFFF); area=0 -> frag_valid_o never asserts; with FRAG_CULL_STATS_EN, stat_culled_o=4 and stat_accepted_o=0.
- Backpressure: frag_busy_i=1 with 20 inside fragments offered back-to-back -> busy_o asserts once count plus in-flight reaches 8; exactly 8 are stored; release frag_busy_i -> all 20 emerge in order with no loss or duplication.
- Full-rate streaming: valid_i held at 1 with 100 inside fragments and frag_busy_i=0 -> busy_o stays 0 and one output per cycle after the 3-cycle latency.
- Simultaneous push/pop at count=FIFO_DEPTH-1 with frag_busy_i toggling every cycle -> count never exceeds FIFO_DEPTH; ordering is checked against a scoreboard.

Source files
------------

// File: rtl/fragment_cull_queue_if.sv
// Fragment stream bundle between the pixel generator, the cull queue and the framebuffer writer.
// The slave modport is the cull queue's view; master is the surrounding environment.
interface fragment_cull_queue_if #(
    parameter int ADDR_W = 20
);
    logic [11:0]       x_i;
    logic [11:0]       y_i;
    logic [24:0]       w0_i;
    logic [24:0]       w1_i;
    logic [24:0]       w2_i;
    logic [23:0]       area_i;
    logic              valid_i;
    logic              busy_o;

    logic [11:0]       frag_x_o;
    logic [11:0]       frag_y_o;
    logic [ADDR_W-1:0] frag_addr_o;
    logic [24:0]       frag_w0_o;
    logic [24:0]       frag_w1_o;
    logic [24:0]       frag_w2_o;
    logic [23:0]       frag_area_o;
    logic              frag_valid_o;
    logic              frag_busy_i;

    modport slave (
        input  x_i, y_i, w0_i, w1_i, w2_i, area_i, valid_i, frag_busy_i,
        output busy_o, frag_x_o, frag_y_o, frag_addr_o, frag_w0_o, frag_w1_o,
               frag_w2_o, frag_area_o, frag_valid_o
    );

    modport master (
        output x_i, y_i, w0_i, w1_i, w2_i, area_i, valid_i, frag_busy_i,
        input  busy_o, frag_x_o, frag_y_o, frag_addr_o, frag_w0_o, frag_w1_o,
               frag_w2_o, frag_area_o, frag_valid_o
    );
endinterface

// File: rtl/fragment_cull_queue.sv
// Culls off-triangle / zero-area / off-screen fragments, computes linear addresses and queues survivors.
// Optional FRAG_CULL_STATS_EN adds kept/culled counters with a synchronous clear.
module fragment_cull_queue #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        fragment_clock_i,
    input  logic                        fragment_reset_i,
    fragment_cull_queue_if.slave        frag
`ifdef FRAG_CULL_STATS_EN
    ,
    input  logic                        stat_clear_i,
    output logic [31:0]                 stat_accepted_o,
    output logic [31:0]                 stat_culled_o
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [11:0]       x;
        logic [11:0]       y;
        logic [ADDR_W-1:0] addr;
        logic [24:0]       w0;
        logic [24:0]       w1;
        logic [24:0]       w2;
        logic [23:0]       area;
    } entry_t;

    logic              accept;
    logic              in_keep;
    logic              s1_valid;
    logic              s1_keep;
    logic [11:0]       s1_x;
    logic [11:0]       s1_y;
    logic [24:0]       s1_w0;
    logic [24:0]       s1_w1;
    logic [24:0]       s1_w2;
    logic [23:0]       s1_area;
    logic              s2_valid;
    logic              s2_keep;
    entry_t            s2_entry;
    entry_t            mem [FIFO_DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              push;
    logic              pop;

    // Busy counts in-flight fragments too, since S1/S2 never stall and must always find FIFO room.
    assign occupancy = OCC_W'(count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
    assign frag.busy_o = occupancy >= OCC_W'(FIFO_DEPTH);
    assign accept = frag.valid_i & ~frag.busy_o;

    assign in_keep = ~frag.w0_i[24] & ~frag.w1_i[24] & ~frag.w2_i[24]
                   & (frag.area_i != 24'd0)
                   & (32'(frag.x_i) < 32'(FB_WIDTH))
                   & (32'(frag.y_i) < 32'(FB_HEIGHT));

    always_ff @(posedge fragment_clock_i or negedge fragment_reset_i) begin
        if (!fragment_reset_i) begin
            s1_valid <= 1'b0;
            s1_keep  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_w0    <= '0;
            s1_w1    <= '0;
            s1_w2    <= '0;
            s1_area  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_keep <= in_keep;
                s1_x    <= frag.x_i;
                s1_y    <= frag.y_i;
                s1_w0   <= frag.w0_i;
                s1_w1   <= frag.w1_i;
                s1_w2   <= frag.w2_i;
                s1_area <= frag.area_i;
            end
        end
    end

    always_ff @(posedge fragment_clock_i or negedge fragment_reset_i) begin
        if (!fragment_reset_i) begin
            s2_valid <= 1'b0;
            s2_keep  <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_keep       <= s1_keep;
                s2_entry.x    <= s1_x;
                s2_entry.y    <= s1_y;
                s2_entry.addr <= ADDR_W'(32'(s1_y) * 32'(FB_WIDTH) + 32'(s1_x));
                s2_entry.w0   <= s1_w0;
                s2_entry.w1   <= s1_w1;
                s2_entry.w2   <= s1_w2;
                s2_entry.area <= s1_area;
            end
        end
    end

    assign push = s2_valid & s2_keep;
    assign pop  = (count != '0) & ~frag.frag_busy_i;

    always_ff @(posedge fragment_clock_i) begin
        if (push) begin
            mem[wr_ptr] <= s2_entry;
        end
    end

    always_ff @(posedge fragment_clock_i or negedge fragment_reset_i) begin
        if (!fragment_reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset, so the head is masked to keep outputs at zero whenever nothing is valid.
    assign frag.frag_valid_o = (count != '0);
    assign head = frag.frag_valid_o ? mem[rd_ptr] : '0;

    assign frag.frag_x_o    = head.x;
    assign frag.frag_y_o    = head.y;
    assign frag.frag_addr_o = head.addr;
    assign frag.frag_w0_o   = head.w0;
    assign frag.frag_w1_o   = head.w1;
    assign frag.frag_w2_o   = head.w2;
    assign frag.frag_area_o = head.area;

`ifdef FRAG_CULL_STATS_EN
    // Clear has priority so a same-cycle increment is lost rather than leaving a count of one.
    always_ff @(posedge fragment_clock_i or negedge fragment_reset_i) begin
        if (!fragment_reset_i) begin
            stat_accepted_o <= '0;
            stat_culled_o   <= '0;
        end else if (stat_clear_i) begin
            stat_accepted_o <= '0;
            stat_culled_o   <= '0;
        end else if (s2_valid) begin
            if (s2_keep) stat_accepted_o <= stat_accepted_o + 32'd1;
            else         stat_culled_o   <= stat_culled_o + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_fragment_cull_queue.sv
// Directed bench for fragment_cull_queue: latency, culling, backpressure, streaming and ordering.
// Stats checks are compiled in only when FRAG_CULL_STATS_EN is defined.
module tb_fragment_cull_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fragment_cull_queue_if frag_if ();

`ifdef FRAG_CULL_STATS_EN
    logic        stat_clear = 1'b0;
    logic [31:0] stat_accepted;
    logic [31:0] stat_culled;
`endif

    fragment_cull_queue dut (
        .fragment_clock_i (clk),
        .fragment_reset_i (rst_n),
        .frag             (frag_if)
`ifdef FRAG_CULL_STATS_EN
        ,
        .stat_clear_i     (stat_clear),
        .stat_accepted_o  (stat_accepted),
        .stat_culled_o    (stat_culled)
`endif
    );

    int checks = 0;
    int errors = 0;
    int next_idx = 0;
    int received = 0;
    logic [11:0] sb_x[$];
    logic [11:0] sb_y[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [11:0] x, input logic [11:0] y,
                                 input logic [24:0] w0, input logic [24:0] w1,
                                 input logic [24:0] w2, input logic [23:0] area,
                                 input logic valid);
        frag_if.x_i     = x;
        frag_if.y_i     = y;
        frag_if.w0_i    = w0;
        frag_if.w1_i    = w1;
        frag_if.w2_i    = w2;
        frag_if.area_i  = area;
        frag_if.valid_i = valid;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] gen_x(input int i);
        return 12'((i * 7) % 600 + 1);
    endfunction

    function automatic logic [11:0] gen_y(input int i);
        return 12'(i % 300 + 5);
    endfunction

    task automatic driveGen(input int i);
        applyStimulus(gen_x(i), gen_y(i), 25'(i), 25'd1, 25'd2, 24'd50, 1'b1);
    endtask

    task automatic monitorOutput();
        logic [11:0] ex;
        logic [11:0] ey;
        if (frag_if.frag_valid_o && !frag_if.frag_busy_i) begin
            if (sb_x.size() == 0) begin
                checkOutput("sb_unexpected_pop", 64'(frag_if.frag_valid_o), 64'd0);
            end else begin
                ex = sb_x.pop_front();
                ey = sb_y.pop_front();
                checkOutput("sb_x", 64'(frag_if.frag_x_o), 64'(ex));
                checkOutput("sb_y", 64'(frag_if.frag_y_o), 64'(ey));
                checkOutput("sb_addr", 64'(frag_if.frag_addr_o), 64'(ey) * 64'd640 + 64'(ex));
                received++;
            end
        end
    endtask

    // Offers fragments base+next_idx.. while popping against the scoreboard until target arrive.
    task automatic streamPhase(input int base, input int total, input int target,
                               input int max_cycles, input bit toggle_busy);
        bit accepted;
        for (int c = 0; c < max_cycles && received < target; c++) begin
            frag_if.frag_busy_i = toggle_busy ? c[0] : 1'b0;
            if (next_idx < total) driveGen(base + next_idx);
            else frag_if.valid_i = 1'b0;
            accepted = frag_if.valid_i && !frag_if.busy_o;
            monitorOutput();
            step();
            if (accepted) begin
                sb_x.push_back(gen_x(base + next_idx));
                sb_y.push_back(gen_y(base + next_idx));
                next_idx++;
            end
        end
        frag_if.valid_i     = 1'b0;
        frag_if.frag_busy_i = 1'b0;
        checkOutput("stream_received", 64'(received), 64'(target));
        checkOutput("stream_sb_empty", 64'(sb_x.size()), 64'd0);
    endtask

    initial begin
        applyStimulus(12'd0, 12'd0, 25'd0, 25'd0, 25'd0, 24'd0, 1'b0);
        frag_if.frag_busy_i = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_valid", 64'(frag_if.frag_valid_o), 64'd0);
        checkOutput("rst_busy", 64'(frag_if.busy_o), 64'd0);
        checkOutput("rst_addr", 64'(frag_if.frag_addr_o), 64'd0);
        #10 rst_n = 1'b1;
        step();

        // Single inside fragment: 2*640+10 = 1290, visible after edge N+2
        applyStimulus(12'd10, 12'd2, 25'd5, 25'd0, 25'd7, 24'd12, 1'b1);
        checkOutput("single_busy", 64'(frag_if.busy_o), 64'd0);
        step();
        frag_if.valid_i = 1'b0;
        checkOutput("single_n0", 64'(frag_if.frag_valid_o), 64'd0);
        step();
        checkOutput("single_n1", 64'(frag_if.frag_valid_o), 64'd0);
        step();
        checkOutput("single_valid", 64'(frag_if.frag_valid_o), 64'd1);
        checkOutput("single_addr", 64'(frag_if.frag_addr_o), 64'd1290);
        checkOutput("single_x", 64'(frag_if.frag_x_o), 64'd10);
        checkOutput("single_y", 64'(frag_if.frag_y_o), 64'd2);
        checkOutput("single_w0", 64'(frag_if.frag_w0_o), 64'd5);
        checkOutput("single_w1", 64'(frag_if.frag_w1_o), 64'd0);
        checkOutput("single_w2", 64'(frag_if.frag_w2_o), 64'd7);
        checkOutput("single_area", 64'(frag_if.frag_area_o), 64'd12);
        step();
        checkOutput("single_popped", 64'(frag_if.frag_valid_o), 64'd0);

`ifdef FRAG_CULL_STATS_EN
        checkOutput("stat_acc_single", 64'(stat_accepted), 64'd1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        checkOutput("stat_acc_clear", 64'(stat_accepted), 64'd0);
        checkOutput("stat_cul_clear", 64'(stat_culled), 64'd0);
`endif

        // Cull set: off-screen x, off-screen y, negative w1, zero area
        applyStimulus(12'd700, 12'd0, 25'd1, 25'd1, 25'd1, 24'd1, 1'b1);
        step();
        applyStimulus(12'd0, 12'd480, 25'd1, 25'd1, 25'd1, 24'd1, 1'b1);
        step();
        applyStimulus(12'd1, 12'd1, 25'd1, 25'h1FFFFFF, 25'd1, 24'd1, 1'b1);
        step();
        applyStimulus(12'd1, 12'd1, 25'd1, 25'd1, 25'd1, 24'd0, 1'b1);
        step();
        frag_if.valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput("cull_no_valid", 64'(frag_if.frag_valid_o), 64'd0);
            step();
        end
`ifdef FRAG_CULL_STATS_EN
        checkOutput("stat_culled", 64'(stat_culled), 64'd4);
        checkOutput("stat_accepted", 64'(stat_accepted), 64'd0);
`endif

        // Corner pixel with all-zero weights is kept: 479*640+639 = 307199
        applyStimulus(12'd639, 12'd479, 25'd0, 25'd0, 25'd0, 24'd1, 1'b1);
        step();
        frag_if.valid_i = 1'b0;
        step();
        step();
        checkOutput("corner_valid", 64'(frag_if.frag_valid_o), 64'd1);
        checkOutput("corner_addr", 64'(frag_if.frag_addr_o), 64'd307199);
        step();
        checkOutput("corner_popped", 64'(frag_if.frag_valid_o), 64'd0);

        // Reset mid-stream with three entries stored
        frag_if.frag_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            driveGen(i);
            step();
        end
        frag_if.valid_i = 1'b0;
        step();
        step();
        step();
        checkOutput("mid_filled", 64'(frag_if.frag_valid_o), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(frag_if.frag_valid_o), 64'd0);
        checkOutput("mid_rst_x", 64'(frag_if.frag_x_o), 64'd0);
        checkOutput("mid_rst_addr", 64'(frag_if.frag_addr_o), 64'd0);
        checkOutput("mid_rst_area", 64'(frag_if.frag_area_o), 64'd0);
        checkOutput("mid_rst_busy", 64'(frag_if.busy_o), 64'd0);
`ifdef FRAG_CULL_STATS_EN
        checkOutput("mid_rst_stat", 64'(stat_accepted), 64'd0);
`endif
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("post_rst_valid", 64'(frag_if.frag_valid_o), 64'd0);
        end
        frag_if.frag_busy_i = 1'b0;

        // Backpressure: 20 offered, exactly 8 accepted while downstream stalls
        sb_x.delete();
        sb_y.delete();
        received = 0;
        next_idx = 0;
        frag_if.frag_busy_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            driveGen(next_idx);
            checkOutput("bp_busy", 64'(frag_if.busy_o), 64'(next_idx >= 8));
            step();
            if (next_idx < 8) begin
                sb_x.push_back(gen_x(next_idx));
                sb_y.push_back(gen_y(next_idx));
                next_idx++;
            end
        end
        frag_if.valid_i = 1'b0;
        step();
        step();
        step();
        checkOutput("bp_full_busy", 64'(frag_if.busy_o), 64'd1);
        checkOutput("bp_head_valid", 64'(frag_if.frag_valid_o), 64'd1);
        checkOutput("bp_head_x", 64'(frag_if.frag_x_o), 64'(gen_x(0)));
        streamPhase(0, 20, 20, 300, 1'b0);

        // Full-rate streaming of 100 fragments
        for (int c = 0; c < 104; c++) begin
            if (c < 100) driveGen(1000 + c);
            else frag_if.valid_i = 1'b0;
            if (c < 100) checkOutput("st_busy", 64'(frag_if.busy_o), 64'd0);
            step();
            if (c >= 2 && c <= 101) begin
                checkOutput("st_valid", 64'(frag_if.frag_valid_o), 64'd1);
                checkOutput("st_x", 64'(frag_if.frag_x_o), 64'(gen_x(1000 + c - 2)));
                checkOutput("st_y", 64'(frag_if.frag_y_o), 64'(gen_y(1000 + c - 2)));
            end else begin
                checkOutput("st_idle", 64'(frag_if.frag_valid_o), 64'd0);
            end
        end

        // Push/pop around count = 7 with downstream stall toggling every cycle
        sb_x.delete();
        sb_y.delete();
        received = 0;
        frag_if.frag_busy_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            driveGen(2000 + i);
            step();
            sb_x.push_back(gen_x(2000 + i));
            sb_y.push_back(gen_y(2000 + i));
        end
        frag_if.valid_i = 1'b0;
        step();
        step();
        step();
        checkOutput("pp_busy_at7", 64'(frag_if.busy_o), 64'd0);
        checkOutput("pp_valid_at7", 64'(frag_if.frag_valid_o), 64'd1);
        next_idx = 0;
        streamPhase(2007, 30, 37, 400, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
